hamming_dist_seq: RTL

//  Parametrised sequential Hamming-distance accumulator for garbled-circuit netlists.
//  - Each accepted beat takes W bits from the garbler (g_input) and W bits from the

---
 rtl/hamming_dist_seq_if.sv | 24 ++
 rtl/hamming_dist_seq.sv | 64 ++++++
 2 files changed

// File: rtl/hamming_dist_seq_if.sv
// hamming_dist_seq_if: job control, beat data, threshold and result bundle for hamming_dist_seq.
interface hamming_dist_seq_if #(
   parameter int N = 1600,
   parameter int W = 8
);
   localparam int OW = $clog2(N + 1);
   logic          start;
   logic          in_valid;
   logic [W-1:0]  g_input;
   logic [W-1:0]  e_input;
   logic [OW-1:0] threshold;
   logic [OW-1:0] o;
   logic          busy;
   logic          done;
   logic          ge;
   modport master (
      output start, in_valid, g_input, e_input, threshold,
      input  o, busy, done, ge
   );
   modport slave (
      input  start, in_valid, g_input, e_input, threshold,
      output o, busy, done, ge
   );
endinterface

// File: rtl/hamming_dist_seq.sv
// hamming_dist_seq: sequential Hamming-distance accumulator, W bits per beat over N/W beats,
// with a registered threshold comparison of the final distance.
module hamming_dist_seq #(
   parameter int N = 1600,
   parameter int W = 8,
   localparam int CC = N / W,
   localparam int OW = $clog2(N + 1),
   localparam int CW = (CC > 1) ? $clog2(CC) : 1,
   localparam int PW = $clog2(W + 1)
) (
   input logic clk,
   input logic rst,
   hamming_dist_seq_if.slave bus
);
   // busy and done are the state bits themselves, so both outputs come straight from flops
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} state_t;
   state_t        state, state_d;
   logic [OW-1:0] o, o_d, sum;
   logic [CW-1:0] cnt, cnt_d;
   logic          ge, ge_d;
   logic [PW-1:0] pop;
   logic          last, beat;
   always_comb begin
      pop = '0;
      for (int i = 0; i < W; i++) pop = pop + PW'(bus.g_input[i] ^ bus.e_input[i]);
   end
   assign sum  = o + OW'(pop);
   assign last = cnt == CW'(CC - 1);
   assign beat = state == RUN && bus.in_valid && !bus.start;
   always_comb begin
      state_d = state;
      o_d     = o;
      cnt_d   = cnt;
      ge_d    = ge;
      if (bus.start) begin
         state_d = RUN;
         o_d     = '0;
         cnt_d   = '0;
         ge_d    = 1'b0;
      end else if (beat) begin
         o_d     = sum;
         cnt_d   = last ? cnt : cnt + CW'(1);
         state_d = last ? DONE : RUN;
         ge_d    = last ? (sum >= bus.threshold) : ge;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         o     <= '0;
         cnt   <= '0;
         ge    <= 1'b0;
      end else begin
         state <= state_d;
         o     <= o_d;
         cnt   <= cnt_d;
         ge    <= ge_d;
      end
   end
   assign bus.o    = o;
   assign bus.busy = state[0];
   assign bus.done = state[1];
   assign bus.ge   = ge;
endmodule
